// File: rtl/traffic_request_conditioner.sv
// Input conditioning for a traffic light controller: synchronizes and debounces
// two vehicle detectors and a pedestrian button, latching pedestrian requests.
module traffic_request_conditioner #(
    parameter int unsigned DEBOUNCE = 4,
    parameter int unsigned MAX_WAIT = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_car_ns,
    input  logic raw_car_ew,
    input  logic raw_ped_btn,
    input  logic walk_active,
    output logic car_ns,
    output logic car_ew,
    output logic ped_button,
    output logic ped_urgent
);

    localparam int unsigned CNT_W  = $clog2(DEBOUNCE + 1);
    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    // Channel index: 0 = N-S detector, 1 = E-W detector, 2 = pedestrian button.
    logic [2:0]       w_raw;
    logic [2:0]       r_meta;
    logic [2:0]       r_sync;
    logic [2:0]       r_d;
    logic [CNT_W-1:0] r_cnt [3];

    assign w_raw = {raw_ped_btn, raw_car_ew, raw_car_ns};

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values, which is what makes the two-stage synchronizer a pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
            r_d    <= '0;
            for (int i = 0; i < 3; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_meta <= w_raw;
            r_sync <= r_meta;
            for (int i = 0; i < 3; i++) begin
                if (r_sync[i] == r_d[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_LAST) begin
                    r_d[i]   <= r_sync[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    logic              r_d_prev;
    logic              r_ped_button;
    logic              r_ped_urgent;
    logic [WAIT_W-1:0] r_wait;
    logic              w_rise;
    logic              w_btn_next;
    logic [WAIT_W-1:0] w_wait_next;
    logic              w_urgent_next;

    assign w_rise = r_d[2] & ~r_d_prev;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_btn_next  = r_ped_button;
        w_wait_next = r_wait;
        if (walk_active) begin
            // A clear beats a simultaneous rise; the press is simply lost.
            w_btn_next  = 1'b0;
            w_wait_next = '0;
        end else if (r_ped_button) begin
            if (r_wait != WAIT_MAX) begin
                w_wait_next = r_wait + WAIT_W'(1);
            end
        end else if (w_rise) begin
            w_btn_next = 1'b1;
        end
        w_urgent_next = w_btn_next && (w_wait_next == WAIT_MAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_d_prev     <= 1'b0;
            r_ped_button <= 1'b0;
            r_wait       <= '0;
            r_ped_urgent <= 1'b0;
        end else begin
            r_d_prev     <= r_d[2];
            r_ped_button <= w_btn_next;
            r_wait       <= w_wait_next;
            r_ped_urgent <= w_urgent_next;
        end
    end

    assign car_ns     = r_d[0];
    assign car_ew     = r_d[1];
    assign ped_button = r_ped_button;
    assign ped_urgent = r_ped_urgent;

endmodule

// File: tb/tb_traffic_request_conditioner.sv
// Bench for traffic_request_conditioner: directed scenarios with fixed expectations
// plus randomized bouncy inputs compared against a sample-window reference model.
module tb_traffic_request_conditioner;

    localparam int unsigned DEB      = 4;
    localparam int unsigned MW       = 20;
    localparam int unsigned WIN_MASK = (1 << DEB) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic raw_car_ns = 1'b0;
    logic raw_car_ew = 1'b0;
    logic raw_ped_btn = 1'b0;
    logic walk_active = 1'b0;
    logic car_ns;
    logic car_ew;
    logic ped_button;
    logic ped_urgent;

    int n_checks = 0;
    int n_errors = 0;

    traffic_request_conditioner #(.DEBOUNCE(DEB), .MAX_WAIT(MW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .raw_car_ns  (raw_car_ns),
        .raw_car_ew  (raw_car_ew),
        .raw_ped_btn (raw_ped_btn),
        .walk_active (walk_active),
        .car_ns      (car_ns),
        .car_ew      (car_ew),
        .ped_button  (ped_button),
        .ped_urgent  (ped_urgent)
    );

    always #5 clk = ~clk;

    // Reference model: a debounced level flips once the last DEB synchronized
    // samples all disagree with it; samples reach the window two edges after raw.
    bit [2:0]    m_meta;
    bit [2:0]    m_sync;
    bit [2:0]    m_d;
    int unsigned m_win [3];
    bit          m_dprev;
    bit          m_btn;
    bit          m_urg;
    int          m_wait;

    task automatic check(input string tag, input logic [7:0] actual, input logic [7:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    task automatic model_reset();
        m_meta  = '0;
        m_sync  = '0;
        m_d     = '0;
        m_dprev = 1'b0;
        m_btn   = 1'b0;
        m_urg   = 1'b0;
        m_wait  = 0;
        for (int i = 0; i < 3; i++) m_win[i] = 0;
    endtask

    task automatic model_step();
        bit [2:0] raw;
        bit       rise;
        bit       old_btn;
        raw     = {raw_ped_btn, raw_car_ew, raw_car_ns};
        rise    = m_d[2] && !m_dprev;
        old_btn = m_btn;
        m_dprev = m_d[2];
        for (int ch = 0; ch < 3; ch++) begin
            m_win[ch] = ((m_win[ch] << 1) | int'(m_sync[ch])) & WIN_MASK;
            if (!m_d[ch] && m_win[ch] == WIN_MASK) m_d[ch] = 1'b1;
            else if (m_d[ch] && m_win[ch] == 0)    m_d[ch] = 1'b0;
        end
        m_sync = m_meta;
        m_meta = raw;
        if (walk_active) begin
            m_btn  = 1'b0;
            m_wait = 0;
        end else if (old_btn) begin
            m_wait = (m_wait < MW) ? m_wait + 1 : MW;
        end else if (rise) begin
            m_btn = 1'b1;
        end
        m_urg = m_btn && (m_wait == MW);
    endtask

    task automatic compare_model();
        check("car_ns_model", car_ns, m_d[0]);
        check("car_ew_model", car_ew, m_d[1]);
        check("ped_button_model", ped_button, m_btn);
        check("ped_urgent_model", ped_urgent, m_urg);
    endtask

    // One clock edge: predict, clock, then sample 1 ns after the edge.
    task automatic step_edge();
        model_step();
        @(posedge clk);
        #1;
        compare_model();
    endtask

    // Asynchronous reset pulse placed mid-cycle, outputs checked while held.
    task automatic async_reset_pulse(input string tag);
        #2 rst_n = 1'b0;
        #1;
        check({tag, "_car_ns"}, car_ns, 1'b0);
        check({tag, "_car_ew"}, car_ew, 1'b0);
        check({tag, "_ped_button"}, ped_button, 1'b0);
        check({tag, "_ped_urgent"}, ped_urgent, 1'b0);
        model_reset();
        #2 rst_n = 1'b1;
    endtask

    initial begin
        int  hold [3];
        bit  lvl [3];
        int  walk_hold;

        model_reset();
        #12;
        check("reset_car_ns", car_ns, 1'b0);
        check("reset_car_ew", car_ew, 1'b0);
        check("reset_ped_button", ped_button, 1'b0);
        check("reset_ped_urgent", ped_urgent, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // N-S rise and fall latency.
        raw_car_ns = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            step_edge();
            check("ns_rise_latency", car_ns, (e >= 6) ? 1'b1 : 1'b0);
        end
        for (int e = 1; e <= 4; e++) step_edge();
        raw_car_ns = 1'b0;
        for (int e = 1; e <= 6; e++) begin
            step_edge();
            check("ns_fall_latency", car_ns, (e >= 6) ? 1'b0 : 1'b1);
        end

        // E-W glitch train 3 high, 1 low, 3 high never settles.
        for (int e = 1; e <= 14; e++) begin
            raw_car_ew = (e <= 3 || (e >= 5 && e <= 7)) ? 1'b1 : 1'b0;
            step_edge();
            check("ew_glitch", car_ew, 1'b0);
        end

        // Pedestrian press, urgency after MAX_WAIT, walk clears both.
        for (int e = 1; e <= 27; e++) begin
            raw_ped_btn = (e <= 10) ? 1'b1 : 1'b0;
            step_edge();
            check("ped_button_latency", ped_button, (e >= 7) ? 1'b1 : 1'b0);
            check("ped_urgent_latency", ped_urgent, (e >= 27) ? 1'b1 : 1'b0);
        end
        walk_active = 1'b1;
        step_edge();
        check("walk_clear_button", ped_button, 1'b0);
        check("walk_clear_urgent", ped_urgent, 1'b0);
        walk_active = 1'b0;
        for (int e = 1; e <= 4; e++) step_edge();

        // Button held through a walk window must not re-request.
        raw_ped_btn = 1'b1;
        for (int e = 1; e <= 7; e++) step_edge();
        check("held_press_sets", ped_button, 1'b1);
        walk_active = 1'b1;
        for (int e = 1; e <= 5; e++) step_edge();
        walk_active = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            step_edge();
            check("held_no_rerequest", ped_button, 1'b0);
        end
        raw_ped_btn = 1'b0;
        for (int e = 1; e <= 6; e++) step_edge();
        raw_ped_btn = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            step_edge();
            check("repress_sets", ped_button, (e >= 7) ? 1'b1 : 1'b0);
        end

        // Async reset with active outputs and inputs still high.
        raw_car_ns = 1'b1;
        for (int e = 1; e <= 8; e++) step_edge();
        check("pre_reset_car_ns", car_ns, 1'b1);
        check("pre_reset_ped_button", ped_button, 1'b1);
        #3 rst_n = 1'b0;
        #1;
        check("async_reset_car_ns", car_ns, 1'b0);
        check("async_reset_ped_button", ped_button, 1'b0);
        check("async_reset_ped_urgent", ped_urgent, 1'b0);
        model_reset();
        @(posedge clk);
        #1;
        check("in_reset_car_ns", car_ns, 1'b0);
        #3 rst_n = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            step_edge();
            check("post_reset_car_ns", car_ns, (e >= 6) ? 1'b1 : 1'b0);
            check("post_reset_ped_button", ped_button, (e >= 7) ? 1'b1 : 1'b0);
        end

        // Randomized bouncy inputs, walk windows and occasional async resets.
        for (int i = 0; i < 3; i++) begin
            hold[i] = 0;
            lvl[i]  = 1'b0;
        end
        walk_hold = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < 3; i++) begin
                if (hold[i] == 0) begin
                    lvl[i]  = ~lvl[i];
                    hold[i] = int'($urandom_range(1, 9));
                end
                hold[i]--;
            end
            raw_car_ns  = lvl[0];
            raw_car_ew  = lvl[1];
            raw_ped_btn = lvl[2];
            if (walk_hold == 0) begin
                walk_active = ($urandom_range(0, 3) == 0);
                walk_hold   = walk_active ? int'($urandom_range(1, 6)) : int'($urandom_range(5, 45));
            end
            walk_hold--;
            step_edge();
            if ($urandom_range(0, 599) == 0) async_reset_pulse("rand_reset");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/traffic_request_conditioner.md
TRAFFIC_REQUEST_CONDITIONER -- requirements
Module: traffic_request_conditioner

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning):
  DEBOUNCE  4   consecutive synchronized cycles an input must hold a new level before the debounced value changes; legal range 1..255
  MAX_WAIT  20  cycles a pedestrian request may stay pending before ped_urgent asserts; legal range 1..255
REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
  clk          in   1  single clock, rising edge
  rst_n        in   1  reset
  raw_car_ns   in   1  asynchronous, bouncy N-S vehicle detector
  raw_car_ew   in   1  asynchronous, bouncy E-W vehicle detector
  raw_ped_btn  in   1  asynchronous, bouncy pedestrian push-button
  walk_active  in   1  synchronous walk indication from the light controller
  car_ns       out  1  debounced N-S presence, registered
  car_ew       out  1  debounced E-W presence, registered
  ped_button   out  1  latched pedestrian request, registered
  ped_urgent   out  1  request pending for MAX_WAIT cycles, registered
REQ-003 The design SHALL use one clock; reset is asynchronous and active-low (clk, rst_n).

Function
REQ-004 Each raw input SHALL pass through its own two-flop synchronizer; s denotes the second-flop output.
REQ-005 Each channel SHALL hold a debounced value d and a counter cnt of width clog2(DEBOUNCE+1).
REQ-006 On each edge where s==d, cnt SHALL be set to 0.
REQ-007 On each edge where s!=d and cnt<DEBOUNCE-1, cnt SHALL be incremented.
REQ-008 On each edge where s!=d and cnt==DEBOUNCE-1, d SHALL take the value of s and cnt SHALL be set to 0.
REQ-009 Latency: a raw level change first sampled at edge 1 and held SHALL change d at edge 2+DEBOUNCE; any raw pulse or glitch whose synchronized width is less than DEBOUNCE cycles SHALL leave d unchanged.
REQ-010 Rising and falling transitions SHALL be debounced symmetrically.
REQ-011 car_ns and car_ew SHALL equal the d of their channels directly.
REQ-012 The ped channel SHALL keep d_prev, a one-cycle-delayed copy of its d; a rise event is d==1 and d_prev==0.
REQ-013 ped_button SHALL set at the edge after a rise event, which is edge 3+DEBOUNCE after the press is first sampled.
REQ-014 ped_button SHALL hold until cleared and SHALL NOT toggle on further presses.
REQ-015 Any edge where walk_active==1 SHALL clear ped_button, the wait counter and ped_urgent.
REQ-016 When a clear and a rise event occur at the same edge, the clear SHALL win and the press is discarded.
REQ-017 A press that rises while walk_active==1 SHALL be discarded.
REQ-018 A button held through the end of a walk SHALL NOT re-request; a new rise event is required.
REQ-019 The wait counter SHALL increment on each edge while ped_button==1 and walk_active==0, saturating at MAX_WAIT.
REQ-020 ped_urgent SHALL be 1 exactly when the wait counter equals MAX_WAIT and ped_button==1, and SHALL be registered.
REQ-021 The three channels SHALL operate fully independently; simultaneous changes on all inputs SHALL each resolve with the latency of REQ-009.

Reset
REQ-022 While rst_n==0, all synchronizer flops, d, d_prev, cnt, the wait counter, car_ns, car_ew, ped_button and ped_urgent SHALL be 0, asynchronously.
REQ-023 Reset asserted mid-debounce or mid-wait SHALL discard the partial count.
REQ-024 After rst_n deasserts, a raw input already held high SHALL be treated as a new 0->1 transition, following REQ-009.

Verification
REQ-025 DEBOUNCE=4: raw_car_ns rises before edge 1 and is held -> car_ns=0 through edge 5 and car_ns=1 after edge 6; raw_car_ns falls later -> car_ns falls 6 edges after the fall is first sampled.
REQ-026 DEBOUNCE=4: raw_car_ew glitches high for 3 cycles, low for 1, then high for 3 -> car_ew stays 0 throughout.
REQ-027 DEBOUNCE=4, MAX_WAIT=20: a 10-cycle raw_ped_btn press -> ped_button=1 after edge 7; ped_urgent=1 20 edges later; walk_active pulsed for one cycle -> both outputs 0 at the next edge.
REQ-028 raw_ped_btn held high across a walk_active window and beyond -> ped_button stays 0 after the clear until the button is released for 4 or more cycles and pressed again.
REQ-029 rst_n asserted asynchronously mid-cycle while ped_button=1 and car_ns=1 -> all outputs 0 immediately; after release with inputs still high -> car_ns returns after edge 6 and ped_button after edge 7.
